// File: rtl/grant_decoder_pkg.sv
// Shared types, default parameters and the one-hot helper for grant_decoder.
// The optional watchdog is enabled by GRANT_DECODER_TIMEOUT_EN (see grant_decoder.sv).
package grant_decoder_pkg;

  localparam int DEF_NO_INPUTS      = 4;
  localparam int DEF_INDEX_WIDTH    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // The one-hot helper works on a fixed 32-bit word, which caps the channel count.
  localparam int MAX_INPUTS = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic onehot_ok(input logic [MAX_INPUTS-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/grant_decoder_onehot_decoder.sv
// Combinational grant classifier: binary index of the set bit plus one-hot and
// all-zero flags. The index is only meaningful when o_is_onehot is high.
module onehot_decoder
  import grant_decoder_pkg::*;
#(
  parameter int NO_INPUTS   = DEF_NO_INPUTS,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic [NO_INPUTS-1:0]   i_grant,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic                   o_is_onehot,
  output logic                   o_is_zero
);

  logic [MAX_INPUTS-1:0] w_grant_ext;

  assign w_grant_ext = MAX_INPUTS'(i_grant);
  assign o_is_onehot = onehot_ok(w_grant_ext);
  assign o_is_zero   = ~|i_grant;

  // OR of the positions of all set bits; exact for a one-hot input.
  always_comb begin
    o_index = '0;
    for (int i = 0; i < NO_INPUTS; i++) begin
      if (i_grant[i]) begin
        o_index = o_index | INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/grant_decoder.sv
// Locks a one-hot arbiter grant into a registered select/index until done,
// then releases through one dead cycle. Define GRANT_DECODER_TIMEOUT_EN for the watchdog.
module grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int NO_INPUTS      = DEF_NO_INPUTS,
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   grant_valid,
  input  logic [NO_INPUTS-1:0]   grant,
  output logic                   grant_ready,
  input  logic                   done,
  output logic [NO_INPUTS-1:0]   select,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   busy,
  output logic                   error,
  output logic                   timeout,
  output state_t                 dbg_state
);

  // Handshake: a grant is taken on a rising edge where grant_valid && grant_ready;
  // grant_ready is high only in IDLE, and nothing presented outside IDLE is seen.

  state_t                 r_state;
  state_t                 w_next_state;
  logic [NO_INPUTS-1:0]   r_select;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_busy;
  logic                   r_error;
  logic [INDEX_WIDTH-1:0] w_index;
  logic                   w_is_onehot;
  logic                   w_is_zero;
  logic                   w_accept;
  logic                   w_error_nxt;
  logic                   w_expired;
  logic                   w_expire;
  logic                   w_unlock;

  if (NO_INPUTS < 2 || NO_INPUTS > MAX_INPUTS || INDEX_WIDTH != $clog2(NO_INPUTS) ||
      TIMEOUT_CYCLES < 2) begin : g_illegal_params
  end

  onehot_decoder #(
    .NO_INPUTS   (NO_INPUTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_onehot_decoder (
    .i_grant     (grant),
    .o_index     (w_index),
    .o_is_onehot (w_is_onehot),
    .o_is_zero   (w_is_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_error_nxt  = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (grant_valid) begin
          if (w_is_onehot) begin
            w_accept     = 1'b1;
            w_next_state = ST_LOCKED;
          end else if (!w_is_zero) begin
            w_error_nxt = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        // done has priority over the watchdog when both land on the same edge.
        if (done) begin
          w_next_state = ST_RELEASE;
        end else if (w_expired) begin
          w_expire     = 1'b1;
          w_next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  assign w_unlock = (r_state == ST_LOCKED) && (w_next_state == ST_RELEASE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_select <= '0;
      r_index  <= '0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_error <= w_error_nxt;
      if (w_accept) begin
        r_select <= grant;
        r_index  <= w_index;
        r_busy   <= 1'b1;
      end else if (w_unlock) begin
        r_select <= '0;
        r_busy   <= 1'b0;
      end
    end
  end

`ifdef GRANT_DECODER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_timeout;

  // Cycles spent in LOCKED since acceptance; saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (r_state == ST_LOCKED && r_count != CNT_MAX) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
    end
  end

  assign w_expired = (r_state == ST_LOCKED) && (r_count == CNT_LAST);
  assign timeout   = r_timeout;
`else
  assign w_expired = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign grant_ready = (r_state == ST_IDLE);
  assign select      = r_select;
  assign index       = r_index;
  assign busy        = r_busy;
  assign error       = r_error;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: directed scenarios plus a randomized
// run against a cycle-level reference model. Follows GRANT_DECODER_TIMEOUT_EN.
module tb_grant_decoder;
  import grant_decoder_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 8;
`ifdef GRANT_DECODER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          grant_valid = 1'b0;
  logic [N-1:0]  grant = '0;
  logic          done = 1'b0;
  logic          grant_ready;
  logic [N-1:0]  select;
  logic [IW-1:0] index;
  logic          busy;
  logic          error;
  logic          timeout;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;

  // Observed outputs packed as {grant_ready, select, index, busy, error, timeout}.
  logic [9:0] obs;
  assign obs = {grant_ready, select, index, busy, error, timeout};

  grant_decoder #(
    .NO_INPUTS      (N),
    .INDEX_WIDTH    (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_ready (grant_ready),
    .done        (done),
    .select      (select),
    .index       (index),
    .busy        (busy),
    .error       (error),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] pk(input logic rdy, input logic [N-1:0] sel,
                                    input logic [IW-1:0] idx, input logic b,
                                    input logic e, input logic t);
    return {rdy, sel, idx, b, e, t};
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [9:0] e;
    reset_n = 1'b0;
    tick();
    e = pk(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held: got %b exp %b", obs, e); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release: got %b exp %b", obs, e); end
  endtask

  task automatic test_basic_lock();
    logic [9:0] e;
    grant = 4'b0100; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0; grant = '0;
    e = pk(1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL basic_lock: got %b exp %b", obs, e); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL basic_hold: got %b exp %b", obs, e); end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    e = pk(1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL basic_release: got %b exp %b", obs, e); end
    tick();
    e = pk(1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL basic_idle_again: got %b exp %b", obs, e); end
  endtask

  task automatic test_multihot_and_zero();
    logic [9:0] e;
    grant = 4'b0110; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0; grant = '0;
    e = pk(1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL multihot_error: got %b exp %b", obs, e); end
    tick();
    e = pk(1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL multihot_pulse_end: got %b exp %b", obs, e); end
    grant = 4'b0000; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL zero_grant_ignored: got %b exp %b", obs, e); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL done_in_idle: got %b exp %b", obs, e); end
    grant = 4'b0001; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0; grant = '0;
    e = pk(1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lock_after_error: got %b exp %b", obs, e); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_ignore_while_locked();
    logic [9:0] e;
    grant = 4'b1000; grant_valid = 1'b1;
    tick();
    grant = 4'b0010;
    e = pk(1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lock_ch3: got %b exp %b", obs, e); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL ignore_new_grant: got %b exp %b", obs, e); end
    end
    grant_valid = 1'b0; grant = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    e = pk(1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL release_ch3: got %b exp %b", obs, e); end
    tick();
  endtask

  task automatic test_watchdog();
    logic [9:0] e;
    // Long lock with no done.
    grant = 4'b0010; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0; grant = '0;
    e = pk(1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < (TO_EN ? TO : 3 * TO); k++) begin
      tick();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL wd_locked k=%0d: got %b exp %b", k, obs, e); end
    end
    if (!TO_EN) begin
      done = 1'b1;
    end
    tick();
    done = 1'b0;
    e = pk(1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, TO_EN);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wd_expiry: got %b exp %b", obs, e); end
    tick();
    e = pk(1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wd_after: got %b exp %b", obs, e); end
    // Same length, done on the expiry edge: done wins, no timeout pulse.
    grant = 4'b1000; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0; grant = '0;
    for (int k = 1; k < TO; k++) begin
      tick();
    end
    e = pk(1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wd_prelast: got %b exp %b", obs, e); end
    done = 1'b1;
    tick();
    done = 1'b0;
    e = pk(1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wd_done_wins: got %b exp %b", obs, e); end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    logic [9:0] e;
    grant = 4'b0100; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0; grant = '0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    e = pk(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL async_reset: got %b exp %b", obs, e); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL post_reset_idle: got %b exp %b", obs, e); end
    grant = 4'b0010; grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0; grant = '0;
    e = pk(1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL post_reset_lock: got %b exp %b", obs, e); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  // Randomized traffic against a model kept as "which channel holds the lock,
  // how many cycles it has held it, and whether we are in the dead cycle".
  task automatic test_random();
    int          m_ch = -1;
    bit          m_dead = 1'b0;
    int          m_age = 0;
    logic [IW-1:0] m_idx = '0;
    bit          e_err;
    bit          e_to;
    logic [N-1:0] e_sel;
    logic [9:0]  e;
    int          kind;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      grant_valid = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      if (kind == 0) grant = '0;
      else if (kind == 1) grant = N'($urandom_range(0, (1 << N) - 1));
      else grant = N'(1 << $urandom_range(0, N - 1));
      done = ($urandom_range(0, 6) == 0);
      e_err = 1'b0;
      e_to  = 1'b0;
      if (m_dead) begin
        m_dead = 1'b0;
      end else if (m_ch >= 0) begin
        m_age++;
        if (done) begin
          m_ch = -1; m_dead = 1'b1;
        end else if (TO_EN && m_age == TO) begin
          e_to = 1'b1; m_ch = -1; m_dead = 1'b1;
        end
      end else if (grant_valid) begin
        if ($countones(grant) == 1) begin
          m_ch = $clog2(grant); m_idx = IW'(m_ch); m_age = 0;
        end else if ($countones(grant) > 1) begin
          e_err = 1'b1;
        end
      end
      tick();
      e_sel = (m_ch >= 0) ? N'(1 << m_ch) : '0;
      e = pk((m_ch < 0) && !m_dead, e_sel, m_idx, m_ch >= 0, e_err, e_to);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL random cyc=%0d: got %b exp %b", cyc, obs, e); end
    end
    grant_valid = 1'b0; grant = '0; done = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_lock();
    test_multihot_and_zero();
    test_ignore_while_locked();
    test_watchdog();
    test_reset_mid_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
# grant_decoder

Consumes the one-hot grant vector produced by the MAC's port arbitration logic and turns it into a locked, binary-indexed channel selection for the duration of one frame transfer. The block accepts a grant through a valid/ready handshake and rejects malformed (multi-hot) grants. It holds the selection until the selected channel signals end-of-frame, or until an optional watchdog expires, then releases through a guaranteed dead cycle. It sits between the arbiter and the TX/RX datapath muxes.

## Interface
- NO_INPUTS, 4, number of requesting channels (≥2)
- INDEX_WIDTH, 2, width of binary index; must equal ceil(log2(NO_INPUTS))
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles while locked (≥2); only used when the watchdog is compiled in
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- grant_valid  input  1  grant vector is presented
- grant  input  NO_INPUTS  one-hot grant from the arbiter
- grant_ready  output  1  block can accept a grant; high only in IDLE
- done  input  1  end-of-frame from the selected channel
- select  output  NO_INPUTS  registered one-hot selection; all zeros when not locked
- index  output  INDEX_WIDTH  registered binary index of the selected channel
- busy  output  1  high while LOCKED
- error  output  1  one-cycle pulse: multi-hot grant rejected
- timeout  output  1  one-cycle pulse: watchdog released the lock

## Operation
- States: IDLE, LOCKED, RELEASE.
- IDLE: grant_ready=1 (combinational from state). Acceptance = grant_valid && grant_ready at the clock edge.
  - Exactly one bit set → select=grant, index=position of the set bit, busy=1, counter cleared, go to LOCKED.
  - Two or more bits set → error pulses for one cycle, state stays IDLE, select/index unchanged (zero).
  - All zeros → ignored; no error.
- LOCKED: grant_ready=0. grant and grant_valid are ignored. The counter increments each cycle.
  - done=1 → go to RELEASE.
  - Watchdog compiled in and counter == TIMEOUT_CYCLES-1 with done=0 → timeout pulses, go to RELEASE.
  - done and expiry in the same cycle → done wins; no timeout pulse.
- RELEASE: select=0, busy=0, index holds its last value, grant_ready=0. Unconditionally go to IDLE next cycle.
- done in IDLE or RELEASE is ignored.
- Counter width is ceil(log2(TIMEOUT_CYCLES)); it saturates and never wraps.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; select=0, index=0, busy=0, error=0, timeout=0, counter=0.
  - grant_ready=1 immediately after reset.
- Accept latency: grant sampled at edge N → select, index and busy valid after edge N; error likewise after edge N for one cycle.
- Release latency: done sampled at edge M → select=0 and busy=0 after edge M; grant_ready=1 after edge M+1. The minimum gap between two locks is one dead cycle.
- Watchdog: lock at edge N with no done → timeout pulse and select=0 after edge N+TIMEOUT_CYCLES.
- Reset asserted mid-lock → immediate return to reset values; no error or timeout pulse.

## Configuration
- GRANT_DECODER_TIMEOUT_EN defined:
  - Watchdog counter present; timeout behaves as above.
- Not defined:
  - No counter logic; timeout is tied to 0.
  - LOCKED exits only on done.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package grant_decoder_pkg:
  - state enum (IDLE, LOCKED, RELEASE);
  - default parameter constants;
  - onehot-valid check function.
- One sub-module, onehot_decoder:
  - purely combinational, parameterised by NO_INPUTS/INDEX_WIDTH;
  - outputs the binary index plus is_onehot and is_zero flags.
- The top level holds the FSM, registers and watchdog.

## Test plan
- Reset release → grant_ready=1, select=0, index=0, busy=0, error=0, timeout=0.
- grant=4'b0100 valid one cycle → next cycle select=4'b0100, index=2, busy=1. done after 5 cycles → select=0, busy=0. One cycle later grant_ready=1.
- grant=4'b0110 valid in IDLE → error high exactly one cycle, select stays 0, grant_ready stays 1. Then grant=4'b0001 → index=0 locked.
- Locked on 4'b1000, new grant=4'b0010 presented while LOCKED → ignored, select stays 4'b1000, index=3.
- With GRANT_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - lock with no done → timeout pulse and select=0 exactly 8 cycles after lock;
  - rerun with done asserted on the expiry cycle → no timeout pulse.
- reset_n pulled low two cycles into a lock → outputs return to reset values asynchronously. After release the block accepts grant=4'b0010 normally.
